// File: rtl/shr_host_driver.sv
// -----------------------------------------------------------------------------
// shr_host_driver
//
// Host-side driver for a serial shift-register test harness. It accepts one
// N_BITS-wide stimulus vector and shifts it MSB-first into the target's din
// chain. It then pulses a one-cycle load/capture strobe and shifts the target's
// dout chain back in. The result is returned as one response vector.
//
// Transaction timeline, with acceptance at edge A:
//   A+0 .. A+N-1      : SHIFT, di carries req_data[N-1] down to req_data[0]
//   A+N .. A+N+1      : STROBE, stb high for exactly one cycle
//   A+N+2 .. A+2N+1   : CAPTURE, do_in sampled at each edge; first sample -> MSB
//   after A+2N+1      : RESP, rsp_valid high until the response is consumed
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request vector offered
//   req_ready  out  high only in IDLE; accept on req_valid & req_ready
//   req_data   in   [N_BITS] stimulus vector for the target's din
//   rsp_valid  out  high only in RESP
//   rsp_ready  in   response consumed on rsp_valid & rsp_ready
//   rsp_data   out  [N_BITS] captured target dout vector
//   di         out  serial data to the target's shift-in chain
//   stb        out  one-cycle load/capture strobe to the target
//   do_in      in   serial data from the target's shift-out chain
// -----------------------------------------------------------------------------
module shr_host_driver #(
  parameter int N_BITS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_BITS-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N_BITS-1:0] rsp_data,
  output logic              di,
  output logic              stb,
  input  logic              do_in
);

  localparam int              CNT_W = $clog2(N_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STROBE,
    CAPTURE,
    RESP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_BITS-1:0]  r_tx;
  logic [N_BITS-1:0]  r_rx;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_di;
  logic               r_stb;
  logic               w_last;

  // The counter restarts at 0 in every phase. It is only ever compared against
  // N_BITS-1, so it never wraps within a phase.
  assign w_last = (r_cnt == LAST);

  // NOTE: all state is updated with non-blocking assignments. This way every
  // branch reads the values from before the edge. The shift registers can
  // then update in the same edge that consumes their old MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_di        <= 1'b0;
      r_stb       <= 1'b0;
      // NOTE: the data registers are reset on purpose. rsp_data is r_rx, and
      // it must read 0 while in reset. Clearing r_tx as well keeps any partly
      // shifted vector from an aborted transaction out of later cycles.
      r_tx        <= '0;
      r_rx        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_req_ready && req_valid) begin
            // The MSB goes straight to di. The remaining bits queue behind it.
            r_di        <= req_data[N_BITS-1];
            r_tx        <= {req_data[N_BITS-2:0], 1'b0};
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= SHIFT;
          end else begin
            // Also covers the first edge after reset release.
            r_req_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (w_last) begin
            r_di    <= 1'b0;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= STROBE;
          end else begin
            r_di  <= r_tx[N_BITS-1];
            r_tx  <= {r_tx[N_BITS-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STROBE: begin
          // The target loads and captures on this edge. Its dout MSB can first
          // be sampled on the next edge.
          r_stb   <= 1'b0;
          r_cnt   <= '0;
          r_state <= CAPTURE;
        end

        CAPTURE: begin
          r_rx <= {r_rx[N_BITS-2:0], do_in};
          if (w_last) begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RESP: begin
          // r_rx does not shift here, so rsp_data holds until the handshake.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_di        <= 1'b0;
          r_stb       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rx;
  assign di        = r_di;
  assign stb       = r_stb;

endmodule

// File: tb/tb_shr_host_driver.sv
// -----------------------------------------------------------------------------
// tb_shr_host_driver
//
// Drives shr_host_driver against a loopback target harness. The target shifts
// di in every cycle. On stb it copies its shift-in register to din, and it
// loads its previous din into the shift-out register. Otherwise it shifts out
// MSB-first.
//
// The response to each transaction is therefore the stimulus of the previous
// transaction that got as far as its strobe. The bench tracks that value in
// exp_prev.
//
// A second instance with N_BITS=8 covers the small-parameter case.
// -----------------------------------------------------------------------------
module tb_shr_host_driver;

  localparam int N = 256;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, rsp_valid, rsp_ready, di, stb, do_in;
  logic [N-1:0] req_data, rsp_data;

  logic         req_valid8, req_ready8, rsp_valid8, rsp_ready8, di8, stb8, do_in8;
  logic [M-1:0] req_data8, rsp_data8;

  int n_vec  = 0;
  int n_miss = 0;

  logic [N-1:0] exp_prev = '0;

  always #5 clk = ~clk;

  shr_host_driver #(.N_BITS(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .di(di), .stb(stb), .do_in(do_in)
  );

  shr_host_driver #(.N_BITS(M)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_data(req_data8),
    .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_data(rsp_data8),
    .di(di8), .stb(stb8), .do_in(do_in8)
  );

  // Loopback target harness. It has no reset of its own, as in the real
  // target.
  logic [N-1:0] t_shr = '0, t_din = '0, t_out = '0;
  always @(posedge clk) begin
    t_shr <= {t_shr[N-2:0], di};
    if (stb) begin
      t_din <= t_shr;
      t_out <= t_din;
    end else begin
      t_out <= t_out << 1;
    end
  end
  assign do_in = t_out[N-1];

  logic [M-1:0] t8_shr = '0, t8_din = '0, t8_out = '0;
  always @(posedge clk) begin
    t8_shr <= {t8_shr[M-2:0], di8};
    if (stb8) begin
      t8_din <= t8_shr;
      t8_out <= t8_din;
    end else begin
      t8_out <= t8_out << 1;
    end
  end
  assign do_in8 = t8_out[M-1];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full transaction. Noise on req_valid and rsp_ready is applied while
  // the transaction is busy. The response is held back for `hold` cycles.
  task automatic do_txn(input logic [N-1:0] data, input int hold);
    int lat;
    int bound;
    bound = 0;
    while (!req_ready && bound < 1000) begin tick(); bound++; end
    check("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_data  = data;
    tick();                                   // edge A
    req_data  = rand_vec();
    check("req_ready_after_accept", req_ready, 0);
    for (int i = 0; i < N; i++) begin
      check("di_bit", di, data[N-1-i]);
      check("stb_low_in_shift", stb, 0);
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("stb_pulse", stb, 1);               // after A+N
    check("di_low_in_strobe", di, 0);
    tick();
    check("stb_single_cycle", stb, 0);        // after A+N+1
    lat = N + 1;
    while (!rsp_valid && lat < 3 * N) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("latency", lat, 2 * N + 1);
    check("rsp_data", rsp_data, exp_prev);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_prev);
      check("hold_req_ready", req_ready, 0);
      check("hold_di", di, 0);
      check("hold_stb", stb, 0);
    end
    rsp_ready = 1'b1;
    tick();                                   // response handshake
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_after_rsp", req_ready, 1);
    exp_prev = data;
  endtask

  task automatic do_txn8(input logic [M-1:0] data, input logic [M-1:0] exp);
    int lat;
    int bound;
    bound = 0;
    while (!req_ready8 && bound < 100) begin tick(); bound++; end
    check("r8_req_ready", req_ready8, 1);
    req_valid8 = 1'b1;
    req_data8  = data;
    tick();
    req_valid8 = 1'b0;
    req_data8  = ~data;
    lat = 0;
    while (!rsp_valid8 && lat < 100) begin tick(); lat++; end
    check("r8_latency", lat, 2 * M + 1);
    check("r8_rsp_data", rsp_data8, exp);
    rsp_ready8 = 1'b1;
    tick();
    rsp_ready8 = 1'b0;
    check("r8_rsp_valid_drop", rsp_valid8, 0);
  endtask

  initial begin
    logic [N-1:0] d1, d2;
    int           cyc, n_stb;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    req_valid8 = 1'b0;
    req_data8  = '0;
    rsp_ready8 = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_di", di, 0);
    check("rst_stb", stb, 0);
    rst_n = 1'b1;
    #1;
    check("req_ready_before_first_edge", req_ready, 0);
    tick();
    check("req_ready_first_edge", req_ready, 1);

    // Loopback: the first response is the empty target, then 256'h1.
    // The second transaction also checks MSB/LSB order and 100 cycles of
    // response backpressure.
    do_txn(N'(1), 0);
    d1 = '0;
    d1[N-1] = 1'b1;
    d1[0]   = 1'b1;
    do_txn(d1, 100);

    // Random vectors with short random backpressure
    for (int k = 0; k < 3; k++) do_txn(rand_vec(), int'($urandom_range(0, 5)));

    // Back-to-back: req_valid and rsp_ready held high
    d1 = rand_vec();
    d2 = rand_vec();
    req_data  = d1;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();                                   // accept d1
    req_data = d2;
    n_stb = 0;
    cyc   = 0;
    while (!rsp_valid && cyc < 3 * N) begin
      if (stb) n_stb++;
      tick();
      cyc++;
    end
    check("b2b_latency", cyc, 2 * N + 1);
    check("b2b_stb_count_1", n_stb, 1);
    check("b2b_rsp_data_1", rsp_data, exp_prev);
    tick();                                   // response handshake
    check("b2b_req_ready_after_rsp", req_ready, 1);
    check("b2b_rsp_valid_drop", rsp_valid, 0);
    tick();                                   // second accept
    req_valid = 1'b0;
    check("b2b_second_accept", req_ready, 0);
    check("b2b_second_di_msb", di, d2[N-1]);
    n_stb = 0;
    cyc   = 0;
    while (!rsp_valid && cyc < 3 * N) begin
      if (stb) n_stb++;
      tick();
      cyc++;
    end
    check("b2b_stb_count_2", n_stb, 1);
    check("b2b_rsp_data_2", rsp_data, d1);
    tick();
    rsp_ready = 1'b0;
    check("b2b_rsp_valid_drop_2", rsp_valid, 0);
    exp_prev = d2;

    // Reset in the middle of CAPTURE. The strobe has already fired, so the
    // target holds the aborted stimulus.
    d1 = rand_vec();
    req_data  = d1;
    req_valid = 1'b1;
    tick();                                   // edge A
    req_valid = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", req_ready, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_di", di, 0);
    check("abort_stb", stb, 0);
    tick();
    tick();
    check("abort_rsp_valid_held", rsp_valid, 0);
    check("abort_req_ready_held", req_ready, 0);
    rst_n = 1'b1;
    tick();
    check("abort_req_ready_release", req_ready, 1);
    check("abort_no_rsp", rsp_valid, 0);
    exp_prev = d1;
    do_txn(rand_vec(), 2);

    // Small parameter
    do_txn8(8'hA5, 8'h00);
    d1 = rand_vec();
    do_txn8(d1[M-1:0], 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shr_host_driver.md
SHR_HOST_DRIVER -- requirements
Module: shr_host_driver

Interface
REQ-001 SHALL have parameter N_BITS, default 256, the serial chain length (din/dout vector width of the target harness).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request vector offered.
REQ-005 SHALL have port req_ready  output  1  request accepted on edge where req_valid&req_ready.
REQ-006 SHALL have port req_data  input  N_BITS  stimulus vector for the target's din.
REQ-007 SHALL have port rsp_valid  output  1  response vector available.
REQ-008 SHALL have port rsp_ready  input  1  response consumed on edge where rsp_valid&rsp_ready.
REQ-009 SHALL have port rsp_data  output  N_BITS  captured target dout vector.
REQ-010 SHALL have port di  output  1  serial data to the target's shift-in chain.
REQ-011 SHALL have port stb  output  1  one-cycle load/capture strobe to the target.
REQ-012 SHALL have port do_in  input  1  serial data from the target's shift-out chain (MSB of its output shift register).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, STROBE, CAPTURE, RESP; di, stb, rsp_data driven from registers only.
REQ-014 SHALL assert req_ready only in IDLE; rsp_valid only in RESP.
REQ-015 On acceptance at edge A SHALL latch req_data into a TX shift register, clear bit counter, enter SHIFT.
REQ-016 In SHIFT SHALL present req_data[N_BITS-1] first, then descending bits, one per cycle; bit k valid after edge A+(N_BITS-1-k), target samples it at the following edge.
REQ-017 After N_BITS bits (after edge A+N_BITS-1 + 1 = A+N_BITS) SHALL enter STROBE with stb=1 for exactly one cycle (high between edges A+N_BITS and A+N_BITS+1).
REQ-018 SHALL then enter CAPTURE and sample do_in at edges A+N_BITS+2 .. A+2*N_BITS+1, shifting into RX register LSB-side ({rx, do_in}); first sampled bit becomes rsp_data[N_BITS-1].
REQ-019 After the N_BITS-th sample SHALL enter RESP; rsp_valid rises after edge A+2*N_BITS+1 (total 2*N_BITS+1 cycles from acceptance; 513 at default).
REQ-020 rsp_data SHALL hold stable while rsp_valid=1; on rsp handshake SHALL return to IDLE; new request acceptable the following cycle.
REQ-021 di SHALL be 0 outside SHIFT; stb SHALL be 0 outside STROBE.
REQ-022 Counter SHALL be $clog2(N_BITS)+1 bits, saturating-free: compares to N_BITS-1 exactly, never wraps within a phase.
REQ-023 req_valid changes outside IDLE and req_data changes after acceptance SHALL have no effect on the transaction in progress.
REQ-024 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-025 While rst_n=0 (asynchronously, including mid-transaction): state=IDLE, counter=0, di=0, stb=0, rsp_valid=0, rsp_data=0, req_ready=0.
REQ-026 req_ready SHALL rise on the first rising clk edge after rst_n deasserts; aborted transaction SHALL never produce a response.

Verification
REQ-027 Loopback: target model = N_BITS shift-in, stb copies din_shr to din and dout:=din into shift-out; req 256'h1 -> rsp_valid exactly 513 cycles after accept, rsp_data equals previous din (0 first, then 256'h1 on second transaction).
REQ-028 Bit order: req_data=256'h8000...0001 -> di=1 first cycle of SHIFT, 0 for 254 cycles, 1 on last; stb high one cycle immediately after.
REQ-029 Backpressure: hold rsp_ready=0 for 100 cycles -> rsp_valid and rsp_data stable, req_ready=0, di=0, stb=0 throughout.
REQ-030 Back-to-back: req_valid held high, rsp_ready=1 -> second accept occurs one cycle after first rsp handshake; exactly one stb per transaction.
REQ-031 Reset mid-CAPTURE (cycle 300): all outputs 0 immediately, no rsp_valid; req_ready=1 after first edge post-deassert; next transaction completes correctly.
REQ-032 Parameter N_BITS=8: req 8'hA5 -> latency 17 cycles, captured vector matches model.
